mul_arbiter: RTL

- Round-robin arbiter and sequencer that shares one Multiplier instance among NREQ requesters.
- Each requester presents operands and holds REQ. The arbiter grants one requester and drives the Multiplier IEA/IEB/OE handshake to completion.
- It returns the product with a one-cycle ACK to the granted requester.
- Sits between client datapaths and the single Multiplier; a watchdog flags a Multiplier that never raises OE.

---
 rtl/mul_arbiter_if.sv | 37 +++
 rtl/mul_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter_if.sv
// ============================================================================
// Module  : mul_arbiter_if
// Brief   : Requester and Multiplier signal bundle for mul_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mul_arbiter_if #(
    parameter int BITS = 8,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] a;
    logic [NREQ*BITS-1:0] b;
    logic [NREQ-1:0]      ack;
    logic [BITS-1:0]      res;
    logic                 err;
    logic                 busy;
    logic [BITS-1:0]      ma;
    logic [BITS-1:0]      mb;
    logic                 miea;
    logic                 mieb;
    logic [BITS-1:0]      my;
    logic                 moe;

    modport slave (
        input  req, a, b, my, moe,
        output ack, res, err, busy, ma, mb, miea, mieb
    );

    modport master (
        output req, a, b, my, moe,
        input  ack, res, err, busy, ma, mb, miea, mieb
    );
endinterface

`default_nettype wire

// File: rtl/mul_arbiter.sv
// ============================================================================
// Module  : mul_arbiter
// Brief   : Round-robin arbiter sharing one Multiplier among NREQ requesters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_arbiter #(
    parameter int BITS    = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  wire logic      clk_i,
    input  wire logic      rstn_i,
    mul_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT_OE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] ma_q, ma_d;
    logic [BITS-1:0] mb_q, mb_d;
    logic [BITS-1:0] res_q, res_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            miea_q, miea_d;
    logic            mieb_q, mieb_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic            found_w;
    logic [PW-1:0]   sel_w;

    // Search order starts just after the last served requester.
    always_comb begin
        found_w = 1'b0;
        sel_w   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found_w && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                found_w = 1'b1;
                sel_w   = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        res_d   = res_q;
        ack_d   = ack_q;
        miea_d  = miea_q;
        mieb_d  = mieb_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                // A stale OE from an abandoned operation must clear first.
                if (found_w && !bus.moe) begin
                    ma_d    = bus.a[int'(sel_w)*BITS +: BITS];
                    mb_d    = bus.b[int'(sel_w)*BITS +: BITS];
                    gnt_d   = sel_w;
                    miea_d  = 1'b1;
                    mieb_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                miea_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT_OE;
            end
            S_WAIT_OE: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.moe) begin
                    res_d   = bus.my;
                    err_d   = 1'b0;
                    mieb_d  = 1'b0;
                    state_d = S_DRAIN;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    mieb_d  = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.moe) begin
                    ack_d        = '0;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                ack_d   = '0;
                ptr_d   = gnt_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            res_q   <= '0;
            ack_q   <= '0;
            miea_q  <= 1'b0;
            mieb_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            res_q   <= res_d;
            ack_q   <= ack_d;
            miea_q  <= miea_d;
            mieb_q  <= mieb_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack  = ack_q;
    assign bus.res  = res_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
    assign bus.ma   = ma_q;
    assign bus.mb   = mb_q;
    assign bus.miea = miea_q;
    assign bus.mieb = mieb_q;

endmodule

`default_nettype wire
